// File: rtl/d16_fetch.sv
// d16_fetch: PC owner and instruction fetcher with a 2-entry decode queue; define D16_FETCH_PERF_EN for perf counters
module d16_fetch #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        jmp_load,
  input  logic [15:0] jmp_addr,
  output logic        im_req,
  output logic [15:0] im_addr,
  input  logic        im_ack,
  input  logic [15:0] im_dat,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  input  logic        ir_ready,
  output logic        ir_flush
`ifdef D16_FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_killed
`endif
);
  typedef enum logic [1:0] {FETCH, FULL, KILL} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, kaddr_q, kaddr_d;
  logic [1:0] cnt_q, cnt_d, cnt_p;
  logic [31:0] q0_q, q0_d, q1_q, q1_d;
  logic live, ack, pop;
  always_comb begin
    live = state_q != FULL;
    ack = live & im_ack;
    pop = ir_valid & ir_ready;
    cnt_p = cnt_q - {1'b0, pop};
    state_d = state_q;
    pc_d = pc_q;
    kaddr_d = kaddr_q;
    cnt_d = cnt_p;
    q0_d = pop ? q1_q : q0_q;
    q1_d = q1_q;
    if (jmp_load) begin
      // an unacked request must still be completed, so remember its address
      pc_d = jmp_addr;
      cnt_d = 2'd0;
      state_d = (live & !im_ack) ? KILL : FETCH;
      kaddr_d = (state_q == FETCH) ? pc_q : kaddr_q;
    end else if (state_q == KILL) begin
      state_d = im_ack ? FETCH : KILL;
    end else begin
      if (ack) begin
        pc_d = pc_q + 16'd1;
        cnt_d = cnt_p + 2'd1;
        q0_d = (cnt_p == 2'd0) ? {pc_q, im_dat} : q0_d;
        q1_d = (cnt_p == 2'd0) ? q1_q : {pc_q, im_dat};
      end
      state_d = (cnt_d == 2'd2) ? FULL : FETCH;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= FETCH;
      pc_q <= RESET_ADDR;
      kaddr_q <= RESET_ADDR;
      cnt_q <= 2'd0;
      q0_q <= 32'd0;
      q1_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      kaddr_q <= kaddr_d;
      cnt_q <= cnt_d;
      q0_q <= q0_d;
      q1_q <= q1_d;
    end
  end
  assign im_req = !sys_rst & live;
  assign im_addr = sys_rst ? RESET_ADDR : (state_q == KILL) ? kaddr_q : pc_q;
  assign ir_valid = cnt_q != 2'd0;
  assign ir = q0_q[15:0];
  assign ir_pc = q0_q[31:16];
  assign ir_flush = sys_rst | jmp_load;
`ifdef D16_FETCH_PERF_EN
  logic [15:0] fetched_q, fetched_d, killed_q, killed_d;
  always_comb begin
    fetched_d = fetched_q + {15'd0, ack & !jmp_load & (state_q == FETCH)};
    killed_d = killed_q + (jmp_load ? {14'd0, cnt_q} : 16'd0)
             + {15'd0, ack & (jmp_load | (state_q == KILL))};
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fetched_q <= 16'd0;
      killed_q <= 16'd0;
    end else begin
      fetched_q <= fetched_d;
      killed_q <= killed_d;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_killed = killed_q;
`endif
endmodule

// File: doc/d16_fetch.md
Name: d16_fetch

Overview:
- Instruction fetch sequencer for the d16 core.
- Owns the program counter and issues word requests to instruction memory.
- Buffers fetched words in a 2-entry queue feeding decode.
- Applies redirects from the jump unit: load PC, flush queue, discard the in-flight fetch.

Parameters:
RESET_ADDR, 16'h0000, PC value loaded on reset.

Ports:
sys_clk  in  1  clock; all state updates on rising edge
sys_rst  in  1  synchronous active-high reset
jmp_load  in  1  redirect request from jump unit, one-cycle pulse
jmp_addr  in  16  redirect target (word address), valid when jmp_load=1
im_req  out  1  instruction memory request
im_addr  out  16  word address of request; stable while im_req=1 and im_ack=0
im_ack  in  1  memory accepts request and returns im_dat this cycle
im_dat  in  16  instruction word, valid when im_ack=1
ir_valid  out  1  ir/ir_pc hold a valid instruction
ir  out  16  instruction word at queue head
ir_pc  out  16  address of ir
ir_ready  in  1  decode consumes head when ir_valid=1 and ir_ready=1
ir_flush  out  1  one-cycle pulse: decode must drop its current latched instruction

Behaviour:
- Reset (sys_rst=1 at edge):
  - pc=RESET_ADDR, queue empty, state=FETCH, kill=0.
  - Outputs: im_req=0, im_addr=RESET_ADDR, ir_valid=0, ir=0, ir_pc=0, ir_flush=1.
  - ir_flush is combinationally forced to 1 while sys_rst=1.
- An in-flight request is abandoned on reset. Memory tolerates im_req deasserting without ack.
- State machine:
  - FETCH: im_req=1, im_addr=pc.
    - im_ack=1: write {pc, im_dat} to queue tail; pc=pc+1, wrapping 16'hFFFF->16'h0000.
    - Then stay in FETCH if a slot remains, else go to FULL.
  - FULL: im_req=0. Return to FETCH on any cycle where the queue has a free slot.
  - KILL: im_req=1, im_addr held at the abandoned address.
    - im_ack=1: data discarded, pc unchanged; go to FETCH.
- Queue capacity:
  - count = number of queued words, range 0..2.
  - FETCH is entered, or kept, only when count after this cycle's pop is < 2.
  - Combinational im_ack in the same cycle as im_req is legal; a word is accepted every cycle when decode drains.
- Consumption:
  - Head pops at the edge when ir_valid & ir_ready.
  - ir_valid = (count != 0). ir/ir_pc come from the head register, no combinational path from im_dat.
- Redirect (jmp_load=1 at edge, not in reset):
  - pc=jmp_addr; queue emptied; ir_flush=1 during that cycle (combinational from jmp_load).
  - If state=FETCH and im_ack=0: go to KILL; im_addr stays at the old address until ack.
  - Otherwise, including im_ack=1 in the same cycle: the acked word is discarded; go to FETCH with im_addr=jmp_addr next cycle.
  - jmp_load during KILL: pc=jmp_addr; stay in KILL.
  - jmp_load wins over a simultaneous pop and a simultaneous queue write.
- Latency:
  - Reset release to first im_req: the cycle after the last reset cycle.
  - im_ack to ir_valid: 1 cycle.
  - jmp_load to im_req at target: 1 cycle, plus the remaining wait for the killed ack.
- Wrap-around: pc increments modulo 2^16; ir_pc reflects the wrapped value.

Optional Feature:
- D16_FETCH_PERF_EN:
  - Adds outputs perf_fetched[15:0], the count of words written to the queue.
  - Adds perf_killed[15:0], the count of words dropped: flushed queue entries plus discarded acks.
  - Both counters wrap, are cleared by sys_rst, and update at the same edge as the event.
- Without the macro: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory (im_ack=im_req), ir_ready=1 → im_addr 0,1,2,3 on consecutive cycles; ir_pc 0,1,2 from the cycle after each ack; ir=im_dat per address.
- ir_ready=0 from start, zero-wait memory → exactly 2 acks at addrs 0,1, then im_req=0; ir_ready=1 for one cycle → im_req re-asserts at addr 2.
- 3-wait-state memory; jmp_load with jmp_addr=16'h0040 in wait cycle 1 → im_addr stays old until ack; acked data not seen on ir; next cycle im_addr=16'h0040; ir_flush pulsed once.
- jmp_load with jmp_addr=16'h0100 in the same cycle as im_ack and ir_ready with 2 queued → ir_valid=0 next cycle; first ir_pc after that =16'h0100.
- RESET_ADDR=16'hFFFE, zero-wait → ir_pc sequence FFFE, FFFF, 0000, 0001.
- sys_rst asserted mid-wait (im_req=1, no ack) → next cycle im_req=0, ir_valid=0; after release im_addr=RESET_ADDR.
